// File: rtl/mat2x2_operand_sched_pkg.sv
// mat_pkg: shared widths, FSM states and element/result index constants for the 2x2 matmul feeder
package mat_pkg;
  localparam int BIT_NUM = 18;
  localparam int FRAC_NUM = 9;
  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN} state_t;
  localparam logic [2:0] IDX_A00 = 3'd0;
  localparam logic [2:0] IDX_A01 = 3'd1;
  localparam logic [2:0] IDX_A10 = 3'd2;
  localparam logic [2:0] IDX_A11 = 3'd3;
  localparam logic [2:0] IDX_B00 = 3'd4;
  localparam logic [2:0] IDX_B01 = 3'd5;
  localparam logic [2:0] IDX_B10 = 3'd6;
  localparam logic [2:0] IDX_B11 = 3'd7;
  localparam logic [1:0] C00 = 2'd0;
  localparam logic [1:0] C01 = 2'd1;
  localparam logic [1:0] C10 = 2'd2;
  localparam logic [1:0] C11 = 2'd3;
endpackage

// File: rtl/mat2x2_operand_sched_if.sv
// mat2x2_operand_sched_if: element input stream plus operand and result-tag outputs
interface mat2x2_operand_sched_if #(parameter int BIT_NUM = mat_pkg::BIT_NUM);
  logic               in_valid;
  logic               in_ready;
  logic [BIT_NUM-1:0] in_data;
  logic               op_valid;
  logic [1:0]         op_idx;
  logic [BIT_NUM-1:0] A_00;
  logic [BIT_NUM-1:0] A_01;
  logic [BIT_NUM-1:0] B_00;
  logic [BIT_NUM-1:0] B_10;
  logic               res_valid;
  logic [1:0]         res_idx;
  logic               done;
  modport slave (
    input  in_valid, in_data,
    output in_ready, op_valid, op_idx, A_00, A_01, B_00, B_10, res_valid, res_idx, done
  );
  modport master (
    output in_valid, in_data,
    input  in_ready, op_valid, op_idx, A_00, A_01, B_00, B_10, res_valid, res_idx, done
  );
endinterface

// File: rtl/mat2x2_operand_sched_rf.sv
// mat_operand_rf: 8-entry element buffer, one write port, row i of A and column j of B read out
module mat_operand_rf
  import mat_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [2:0]         waddr,
  input  logic [BIT_NUM-1:0] wdata,
  input  logic               i,
  input  logic               j,
  output logic [BIT_NUM-1:0] a0,
  output logic [BIT_NUM-1:0] a1,
  output logic [BIT_NUM-1:0] b0,
  output logic [BIT_NUM-1:0] b1
);
  logic [BIT_NUM-1:0] mem [8];
  // storage has no reset; contents are only read after a full load
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign a0 = mem[{1'b0, i, 1'b0}];
  assign a1 = mem[{1'b0, i, 1'b1}];
  assign b0 = mem[{2'b10, j}];
  assign b1 = mem[{2'b11, j}];
endmodule

// File: rtl/mat2x2_operand_sched.sv
// mat2x2_operand_sched: buffers A and B, issues the four C=A*B operand sets, tags the dot-product results
module mat2x2_operand_sched
  import mat_pkg::*;
(
  input logic clk,
  input logic srst_n,
  mat2x2_operand_sched_if.slave s
);
  state_t             state;
  logic [2:0]         load_cnt;
  logic [1:0]         issue_cnt;
  logic [1:0]         nxt;
  logic               wr;
  logic               last_ld;
  logic               last_is;
  logic [BIT_NUM-1:0] ra0, ra1, rb0, rb1;
  // transfer qualification and the index whose operands get registered at the next edge
  always_comb begin
    wr = s.in_valid & s.in_ready;
    last_ld = wr && load_cnt == IDX_B11;
    last_is = state == S_ISSUE && issue_cnt == C11;
    nxt = state == S_ISSUE ? issue_cnt + 2'd1 : C00;
  end
  assign s.op_idx = issue_cnt;
  mat_operand_rf u_rf (
    .clk  (clk),
    .we   (wr),
    .waddr(load_cnt),
    .wdata(s.in_data),
    .i    (nxt[1]),
    .j    (nxt[0]),
    .a0   (ra0),
    .a1   (ra1),
    .b0   (rb0),
    .b1   (rb1)
  );
  // FSM with registered handshake, operand and result-tag outputs
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state <= S_LOAD;
      load_cnt <= '0;
      issue_cnt <= '0;
      s.in_ready <= 1'b1;
      s.op_valid <= 1'b0;
      s.A_00 <= '0;
      s.A_01 <= '0;
      s.B_00 <= '0;
      s.B_10 <= '0;
      s.res_valid <= 1'b0;
      s.res_idx <= '0;
      s.done <= 1'b0;
    end else begin
      s.res_valid <= s.op_valid;
      s.res_idx <= s.op_idx;
      s.done <= last_is;
      case (state)
        S_LOAD:
          if (wr) begin
            load_cnt <= load_cnt + 3'd1;
            if (last_ld) begin
              state <= S_ISSUE;
              s.in_ready <= 1'b0;
              s.op_valid <= 1'b1;
              s.A_00 <= ra0;
              s.A_01 <= ra1;
              s.B_00 <= rb0;
              s.B_10 <= rb1;
            end
          end
        S_ISSUE:
          if (last_is) begin
            state <= S_DRAIN;
            issue_cnt <= '0;
            s.op_valid <= 1'b0;
            s.A_00 <= '0;
            s.A_01 <= '0;
            s.B_00 <= '0;
            s.B_10 <= '0;
          end else begin
            issue_cnt <= issue_cnt + 2'd1;
            s.A_00 <= ra0;
            s.A_01 <= ra1;
            s.B_00 <= rb0;
            s.B_10 <= rb1;
          end
        default: begin
          state <= S_LOAD;
          s.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mat2x2_operand_sched.sv
// tb_mat2x2_operand_sched: scoreboard bench with a behavioural dot-product stage on the outputs
module tb_mat2x2_operand_sched;
  typedef struct {
    logic [1:0]        idx;
    logic signed [17:0] a00, a01, b00, b10;
  } op_t;
  typedef struct {
    logic [1:0] idx;
    longint     c;
  } res_t;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  longint c_reg = 0;
  int xfer_cyc = 0;
  int last_start = 0;
  int prev_start = 0;
  op_t exp_op[$];
  res_t exp_c[$];
  int exp_start[$];
  int m_id[8] = '{512, 0, 0, 512, 512, 1024, -512, 256};
  int m_alt[8] = '{256, -256, 1024, 128, 512, 256, -1024, 768};

  mat2x2_operand_sched_if #(.BIT_NUM(18)) s();
  mat2x2_operand_sched dut (.clk(clk), .srst_n(srst_n), .s(s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint mac(input logic signed [17:0] a0, a1, b0, b1);
    return (longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1)) >>> 9;
  endfunction

  always @(posedge clk) c_reg <= mac(s.A_00, s.A_01, s.B_00, s.B_10);

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
    end
  endtask

  op_t e;
  res_t r;
  always @(negedge clk) if (mon_en) begin
    if (s.op_valid) begin
      chk("op_vs_ready", s.in_ready, 0);
      if (exp_op.size() == 0) chk("op_unexpected", 1, 0);
      else begin
        e = exp_op.pop_front();
        chk("op_idx", s.op_idx, e.idx);
        chk("A_00", $signed(s.A_00), e.a00);
        chk("A_01", $signed(s.A_01), e.a01);
        chk("B_00", $signed(s.B_00), e.b00);
        chk("B_10", $signed(s.B_10), e.b10);
        if (e.idx == 2'd0) begin
          if (exp_start.size() == 0) chk("op_start_unexpected", 1, 0);
          else chk("op_start", cyc, exp_start.pop_front());
          prev_start = last_start;
          last_start = cyc;
        end
      end
    end else chk("idle_ops", longint'(s.A_00 | s.A_01 | s.B_00 | s.B_10), 0);
    if (s.res_valid) begin
      chk("done_tag", s.done, s.res_idx == 2'd3);
      if (exp_c.size() == 0) chk("res_unexpected", 1, 0);
      else begin
        r = exp_c.pop_front();
        chk("res_idx", s.res_idx, r.idx);
        chk("C", c_reg, r.c);
      end
    end else chk("done_idle", s.done, 0);
  end

  task automatic push_exp(input int m[8]);
    for (int k = 0; k < 4; k++) begin
      op_t o;
      res_t q;
      int i = k / 2;
      int j = k % 2;
      o.idx = 2'(k);
      o.a00 = 18'(m[2*i]);
      o.a01 = 18'(m[2*i+1]);
      o.b00 = 18'(m[4+j]);
      o.b10 = 18'(m[6+j]);
      q.idx = 2'(k);
      q.c = (longint'(m[2*i]) * m[4+j] + longint'(m[2*i+1]) * m[6+j]) >>> 9;
      exp_op.push_back(o);
      exp_c.push_back(q);
    end
  endtask

  task automatic send(input logic [17:0] d);
    int n = 0;
    s.in_valid = 1'b1;
    s.in_data = d;
    while (!s.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 1, 0);
    xfer_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic send_mat(input int m[8], input bit gap);
    push_exp(m);
    for (int k = 0; k < 8; k++) begin
      send(18'(m[k]));
      if (gap && k < 7) begin
        s.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    exp_start.push_back(xfer_cyc + 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_op.size() != 0 || exp_c.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", n < 100, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    s.in_valid = 1'b0;
    s.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    srst_n = 1'b1;
    chk("rst_in_ready", s.in_ready, 1);
    chk("rst_op_valid", s.op_valid, 0);
    chk("rst_op_idx", s.op_idx, 0);
    chk("rst_ops", longint'(s.A_00 | s.A_01 | s.B_00 | s.B_10), 0);
    chk("rst_res_valid", s.res_valid, 0);
    chk("rst_res_idx", s.res_idx, 0);
    chk("rst_done", s.done, 0);
    mon_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("idle_nothing", longint'({s.op_valid, s.res_valid, s.done}), 0);
      chk("idle_ready", s.in_ready, 1);
    end

    send_mat(m_id, 1'b0);
    s.in_valid = 1'b0;
    wait_idle();

    send_mat(m_id, 1'b1);
    s.in_valid = 1'b0;
    wait_idle();

    send_mat(m_id, 1'b0);
    s.in_data = 18'h3FFFF;
    for (int k = 0; k < 5; k++) begin
      chk("busy_ready", s.in_ready, 0);
      @(posedge clk); #1;
    end
    s.in_valid = 1'b0;
    wait_idle();

    send_mat(m_id, 1'b0);
    send_mat(m_alt, 1'b0);
    s.in_valid = 1'b0;
    wait_idle();
    chk("b2b_period", last_start - prev_start, 13);

    send_mat(m_alt, 1'b0);
    s.in_valid = 1'b0;
    n = 0;
    while (!s.op_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_first_issue", s.op_idx, 0);
    @(posedge clk); #1;
    chk("mid_second_issue", s.op_idx, 1);
    srst_n = 1'b0;
    @(posedge clk); #1;
    exp_op.delete();
    exp_c.delete();
    exp_start.delete();
    chk("mid_rst_quiet", longint'({s.op_valid, s.res_valid, s.done}), 0);
    @(posedge clk); #1;
    chk("mid_rst_quiet2", longint'({s.op_valid, s.res_valid, s.done}), 0);
    srst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", s.in_ready, 1);
    chk("mid_rst_after", longint'({s.op_valid, s.res_valid, s.done}), 0);
    send_mat(m_id, 1'b0);
    s.in_valid = 1'b0;
    wait_idle();

    chk("queues_empty", exp_op.size() + exp_c.size() + exp_start.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
